// File: rtl/push_arbiter.sv
`default_nettype none
// ============================================================================
// push_arbiter : round-robin N:1 arbiter for IPush, one word per grant,
//                with a watchdog that aborts grants the slave never answers.
// Revision     : 1.0
// ============================================================================
module push_arbiter #(
  parameter int N       = 2,
  parameter int DATAW   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic [N-1:0]         in_request,
  input  logic [N*DATAW-1:0]   in_data,
  output logic [N-1:0]         in_done,
  output logic                 out_request,
  output logic [DATAW-1:0]     out_data,
  input  logic                 out_done,
  output logic [$clog2(N)-1:0] grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = $clog2(N);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] rr;
  logic [N-1:0]  mask;
  logic [CW-1:0] count;
  logic [N-1:0]  eligible;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          wd_expire;

  // mask keeps a request held over from the finished grant out of one IDLE sample
  assign eligible  = in_request & ~mask;
  assign wd_expire = (TIMEOUT != 0) && (count == CNT_LAST);

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(rr) + k) % N);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= S_IDLE;
      out_request <= 1'b0;
      out_data    <= '0;
      in_done     <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr          <= IW'(N - 1);
      mask        <= '0;
      count       <= '0;
    end else begin
      in_done     <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          mask  <= '0;
          count <= '0;
          if (found) begin
            grant       <= pick;
            out_data    <= in_data[pick*DATAW +: DATAW];
            out_request <= 1'b1;
            rr          <= pick;
            busy        <= 1'b1;
            state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          count <= count + CW'(1);
          if (out_done) begin
            out_request <= 1'b0;
            in_done     <= N'(1) << grant;
            state       <= S_RELEASE;
          end else if (wd_expire) begin
            out_request <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          mask  <= N'(1) << grant;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          out_request <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_push_arbiter.sv
`default_nettype none
// ============================================================================
// tb_push_arbiter : vector table for single-word and round-robin traffic,
//                   hand sequences for watchdog, collision, reset and masking.
// Revision        : 1.0
// ============================================================================
module tb_push_arbiter;

  localparam int N       = 2;
  localparam int DATAW   = 16;
  localparam int TIMEOUT = 8;
  localparam logic [15:0] D0 = 16'hA5A5;
  localparam logic [15:0] D1 = 16'h5A5A;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [1:0]  in_request = '0;
  logic [31:0] in_data = {D1, D0};
  logic        out_done = 1'b0;
  logic [1:0]  in_done;
  logic        out_request;
  logic [15:0] out_data;
  logic [0:0]  grant;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  push_arbiter #(.N(N), .DATAW(DATAW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nRst(nRst), .in_request(in_request), .in_data(in_data),
    .in_done(in_done), .out_request(out_request), .out_data(out_data),
    .out_done(out_done), .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        od;
    logic [1:0]  done;
    logic        oreq;
    logic        gnt;
    logic        bsy;
    logic        terr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [1:0] q, logic o, logic [1:0] dn,
                              logic oq, logic g, logic b, logic t, logic [15:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.od = o; v.done = dn; v.oreq = oq;
    v.gnt = g; v.bsy = b; v.terr = t; v.data = d;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_request = '0;
    out_done   = 1'b0;
    nRst       = 1'b0;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
  endtask

  function automatic logic [31:0] obs();
    return {10'd0, in_done, out_request, grant, busy, timeout_err, out_data};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // single master m0, slave answers in the second GRANT cycle
    add(1, 2'b01, 0, 2'b00, 1, 0, 1, 0, D0);
    add(0, 2'b01, 0, 2'b00, 1, 0, 1, 0, D0);
    add(0, 2'b01, 1, 2'b01, 0, 0, 1, 0, D0);
    add(0, 2'b01, 0, 2'b00, 0, 0, 0, 0, D0);
    add(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, D0);
    // both masters streaming: grants alternate 0,1,0,1,...
    for (int w = 0; w < 8; w++) begin
      logic g;
      g = w[0];
      add(w == 0, 2'b11, 0, 2'b00,       1, g, 1, 0, g ? D1 : D0);
      add(0,      2'b11, 1, g ? 2'b10 : 2'b01, 0, g, 1, 0, g ? D1 : D0);
      add(0,      2'b11, 0, 2'b00,       0, g, 0, 0, g ? D1 : D0);
    end
    add(0, 2'b00, 0, 2'b00, 0, 1, 0, 0, D1);
    add(0, 2'b00, 0, 2'b00, 0, 1, 0, 0, D1);

    do_reset();
    check("reset_state", obs(), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      in_request = tbl[i].req;
      out_done   = tbl[i].od;
      tick();
      check($sformatf("vec[%0d]", i), obs(),
            {10'd0, tbl[i].done, tbl[i].oreq, tbl[i].gnt, tbl[i].bsy, tbl[i].terr, tbl[i].data});
    end
    out_done = 1'b0;

    // watchdog: slave never answers m1
    do_reset();
    in_request = 2'b10;
    tick();
    check("to_grant", {out_request, grant}, 2'b11);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      check($sformatf("to_hold%0d", i), {out_request, timeout_err, in_done}, 4'b1000);
    end
    tick();
    check("to_abort", {out_request, timeout_err, in_done, busy}, 5'b01001);
    tick();
    check("to_release", {out_request, timeout_err, in_done, busy}, 5'b00000);
    tick();
    check("to_masked", {out_request, busy}, 2'b00);
    tick();
    check("to_regrant", {out_request, grant, busy}, 3'b111);
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    check("to_done", {in_done, timeout_err}, 3'b100);
    in_request = 2'b00;
    repeat (2) tick();

    // out_done lands on the last watchdog cycle: done wins
    do_reset();
    in_request = 2'b01;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("col_pending", {out_request, timeout_err}, 2'b10);
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    check("col_done", {in_done, timeout_err, out_request}, 4'b0100);
    in_request = 2'b00;
    tick();
    check("col_release", {in_done, timeout_err, busy}, 4'b0000);

    // asynchronous reset in the middle of a grant to m1
    do_reset();
    in_request = 2'b10;
    tick();
    check("rst_pre", {out_request, grant, busy}, 3'b111);
    in_request = 2'b11;
    #2 nRst = 1'b0;
    #1;
    check("rst_async", obs(), 32'd0);
    @(posedge clk);
    #1 nRst = 1'b1;
    tick();
    check("rst_m0_first", {out_request, grant, out_data}, {1'b1, 1'b0, D0});
    in_request = 2'b00;
    out_done   = 1'b1;
    tick();
    out_done = 1'b0;
    repeat (2) tick();

    // stale request from m1 held into the masked IDLE cycle
    do_reset();
    in_request = 2'b10;
    tick();
    check("st_grant", {out_request, grant}, 2'b11);
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    check("st_done", in_done, 2'b10);
    tick();
    tick();
    check("st_masked", {out_request, busy}, 2'b00);
    in_request = 2'b00;
    tick();
    check("st_idle", {out_request, busy, in_done}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
